// File: rtl/mipi_rx_frame_assembler.sv
// CSI-2 RX frame assembler: hunts for a start marker, packs DLEN payload bytes
// into a wide register and holds it under a valid/ack handshake.
module mipi_rx_frame_assembler #(
  parameter int unsigned DLEN    = 512,
  parameter logic [47:0] MARKER  = 48'h7e7e7e7e7e7e,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              rx_pixel_clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [47:0]       rx_data,
  output logic [DLEN*8-1:0] data,
  output logic              data_valid,
  input  logic              data_ack,
  output logic              busy,
  output logic              frame_err,
  output logic [7:0]        drop_cnt
);

  localparam int unsigned NB = (DLEN + 5) / 6;
  localparam int unsigned BW = $clog2(NB + 1);
  localparam int unsigned IW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {HUNT, SYNC, COLLECT, DONE} state_t;

  state_t         state, state_nxt;
  logic [BW-1:0]  beat, beat_nxt;
  logic [IW-1:0]  idle, idle_nxt;
  logic           err_nxt;
  logic           wr_en;
  logic [BW-1:0]  wr_beat;
  logic           last_mark, last_mark_nxt;
  logic [7:0]     drop_nxt;
  logic           is_marker;

  assign is_marker  = rx_valid && (rx_data == MARKER);
  assign data_valid = (state == DONE);
  assign busy       = (state == SYNC) || (state == COLLECT);

  always_comb begin
    state_nxt     = state;
    beat_nxt      = beat;
    idle_nxt      = idle;
    err_nxt       = 1'b0;
    wr_en         = 1'b0;
    wr_beat       = beat;
    last_mark_nxt = last_mark;
    drop_nxt      = drop_cnt;
    case (state)
      HUNT: begin
        beat_nxt = '0;
        idle_nxt = '0;
        if (is_marker) state_nxt = SYNC;
      end
      SYNC, COLLECT: begin
        if (rx_valid) begin
          idle_nxt = '0;
          if (state == COLLECT || !is_marker) begin
            wr_en = 1'b1;
            if (state == SYNC) wr_beat = '0;
            beat_nxt = wr_beat + 1'b1;
            if (wr_beat == BW'(NB - 1)) begin
              state_nxt     = DONE;
              last_mark_nxt = 1'b0;
            end else begin
              state_nxt = COLLECT;
            end
          end
        end else if (idle == IW'(TIMEOUT - 1)) begin
          // TIMEOUT-th consecutive idle cycle aborts the frame
          err_nxt   = 1'b1;
          idle_nxt  = '0;
          state_nxt = HUNT;
        end else begin
          idle_nxt = idle + 1'b1;
        end
      end
      DONE: begin
        if (rx_valid) begin
          last_mark_nxt = is_marker;
          if (is_marker && !last_mark && drop_cnt != 8'hff) drop_nxt = drop_cnt + 8'd1;
        end
        if (data_ack) state_nxt = HUNT;
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge rx_pixel_clk) begin
    if (rst) begin
      state     <= HUNT;
      beat      <= '0;
      idle      <= '0;
      frame_err <= 1'b0;
      last_mark <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      beat      <= beat_nxt;
      idle      <= idle_nxt;
      frame_err <= err_nxt;
      last_mark <= last_mark_nxt;
      drop_cnt  <= drop_nxt;
    end
  end

  // Each payload byte has a fixed beat/lane position, so writes are per-byte enables.
  always_ff @(posedge rx_pixel_clk) begin
    if (rst) begin
      data <= '0;
    end else if (wr_en) begin
      for (int unsigned k = 0; k < DLEN; k++) begin
        if (wr_beat == BW'(k / 6)) data[k*8 +: 8] <= rx_data[(k % 6)*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mipi_rx_frame_assembler.sv
// Scoreboard bench for mipi_rx_frame_assembler with DLEN=8 and DLEN=512 instances.
module tb_mipi_rx_frame_assembler;

  localparam logic [47:0] MK = 48'h7e7e7e7e7e7e;
  localparam logic [63:0] FA = 64'h0807060504030201;
  localparam logic [63:0] FB = 64'h1817161514131211;
  localparam logic [63:0] FC = 64'h2827262524232221;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8, v8, ack8, dv8, busy8, err8;
  logic [47:0] d8;
  logic [63:0] data8;
  logic [7:0]  drop8;

  logic          rst5, v5, ack5, dv5, busy5, err5;
  logic [47:0]   d5;
  logic [4095:0] data5;
  logic [7:0]    drop5;

  int passed = 0;
  int total  = 0;
  int err8_seen = 0;
  logic dv8_q = 1'b0;
  logic dv5_q = 1'b0;
  logic [63:0]   q8[$];
  logic [4095:0] q5[$];

  mipi_rx_frame_assembler #(.DLEN(8), .MARKER(MK), .TIMEOUT(1024)) u8 (
    .rx_pixel_clk(clk), .rst(rst8), .rx_valid(v8), .rx_data(d8), .data(data8),
    .data_valid(dv8), .data_ack(ack8), .busy(busy8), .frame_err(err8), .drop_cnt(drop8));

  mipi_rx_frame_assembler #(.DLEN(512), .MARKER(MK), .TIMEOUT(1024)) u5 (
    .rx_pixel_clk(clk), .rst(rst5), .rx_valid(v5), .rx_data(d5), .data(data5),
    .data_valid(dv5), .data_ack(ack5), .busy(busy5), .frame_err(err5), .drop_cnt(drop5));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc8(input logic v, input logic [47:0] d);
    v8 = v; d8 = d;
    @(posedge clk); #1;
  endtask

  task automatic cyc5(input logic v, input logic [47:0] d);
    v5 = v; d5 = d;
    @(posedge clk); #1;
  endtask

  function automatic logic [47:0] pbeat(input int i, input int mode);
    logic [47:0] b;
    int n;
    for (int j = 0; j < 6; j++) begin
      n = 6*i + j;
      b[j*8 +: 8] = (mode == 0) ? 8'(n % 256) : 8'(255 - (n % 256));
    end
    return b;
  endfunction

  function automatic logic [4095:0] pexp(input int mode);
    logic [4095:0] e;
    for (int k = 0; k < 512; k++)
      e[k*8 +: 8] = (mode == 0) ? 8'(k % 256) : 8'(255 - (k % 256));
    return e;
  endfunction

  // Monitors: compare the presented payload whenever data_valid rises.
  always @(negedge clk) begin
    logic [63:0] e8;
    if (err8) err8_seen++;
    if (dv8 && !dv8_q) begin
      total++;
      if (q8.size() == 0) $display("FAIL dlen8_unexpected_frame: got %0h expected none", data8);
      else begin
        e8 = q8.pop_front();
        if (data8 === e8) passed++;
        else $display("FAIL dlen8_payload: got %0h expected %0h", data8, e8);
      end
    end
    dv8_q = dv8;
  end

  always @(negedge clk) begin
    logic [4095:0] e5;
    int bad;
    if (dv5 && !dv5_q) begin
      total++;
      if (q5.size() == 0) $display("FAIL dlen512_unexpected_frame: got frame expected none");
      else begin
        e5 = q5.pop_front();
        bad = -1;
        for (int k = 511; k >= 0; k--) if (data5[k*8 +: 8] !== e5[k*8 +: 8]) bad = k;
        if (bad < 0) passed++;
        else $display("FAIL dlen512_payload: byte %0d got %0h expected %0h",
                      bad, data5[bad*8 +: 8], e5[bad*8 +: 8]);
      end
    end
    dv5_q = dv5;
  end

  initial begin
    int base;
    rst8 = 1; rst5 = 1; v8 = 0; v5 = 0; d8 = '0; d5 = '0; ack8 = 0; ack5 = 0;
    repeat (2) @(posedge clk);
    #1; rst8 = 0; rst5 = 0;

    check("rst_data8", data8, 64'h0);
    check("rst_dv8", dv8, 0);
    check("rst_busy8", busy8, 0);
    check("rst_err8", err8, 0);
    check("rst_drop8", drop8, 0);
    check("rst_data512_zero", (data5 == '0), 1);
    check("rst_dv512", dv5, 0);

    // basic frame
    q8.push_back(FA);
    cyc8(1, MK);                  check("t1_busy_sync", busy8, 1);
    cyc8(1, 48'h060504030201);    check("t1_busy_collect", busy8, 1);
    check("t1_dv_early", dv8, 0);
    cyc8(1, 48'h0c0b0a090807);    check("t1_latency_dv", dv8, 1);
    check("t1_busy_done", busy8, 0);
    cyc8(0, '0);                  check("t1_dv_held", dv8, 1);
    ack8 = 1; cyc8(0, '0); ack8 = 0;
    check("t1_dv_cleared", dv8, 0);

    // preamble markers and short gaps
    q8.push_back(FA);
    base = err8_seen;
    repeat (3) cyc8(1, MK);
    cyc8(1, 48'h060504030201);
    repeat (5) cyc8(0, '0);
    check("t2_busy_gap", busy8, 1);
    cyc8(1, 48'h0c0b0a090807);
    check("t2_dv", dv8, 1);
    check("t2_no_err", err8_seen, base);
    ack8 = 1; cyc8(0, '0); ack8 = 0;

    // idle timeout
    cyc8(1, MK);
    cyc8(1, 48'h060504030201);
    repeat (1023) cyc8(0, '0);
    check("t3_no_err_1023", err8, 0);
    check("t3_busy_1023", busy8, 1);
    cyc8(0, '0);
    check("t3_err_pulse", err8, 1);
    check("t3_hunt", busy8, 0);
    check("t3_dv", dv8, 0);
    cyc8(0, '0);
    check("t3_err_single", err8, 0);
    q8.push_back(FB);
    cyc8(1, MK);
    cyc8(1, 48'h161514131211);
    cyc8(1, 48'hffffffff1817);
    check("t3_recover_dv", dv8, 1);
    ack8 = 1; cyc8(0, '0); ack8 = 0;

    // drops while holding
    q8.push_back(FA);
    cyc8(1, MK); cyc8(1, 48'h060504030201); cyc8(1, 48'h0c0b0a090807);
    cyc8(1, MK); cyc8(1, MK); cyc8(1, 48'h111111111111); cyc8(1, 48'h111111111111);
    cyc8(1, MK); cyc8(1, 48'h222222222222);
    cyc8(0, '0);
    check("t4_drop_cnt", drop8, 8'd2);
    check("t4_data_held", data8, FA);
    check("t4_dv_held", dv8, 1);
    ack8 = 1; cyc8(0, '0); ack8 = 0;
    check("t4_dv_after_ack", dv8, 0);
    q8.push_back(FC);
    cyc8(1, MK); cyc8(1, 48'h262524232221); cyc8(1, 48'h000000002827);
    check("t4_next_dv", dv8, 1);
    check("t4_drop_kept", drop8, 8'd2);
    ack8 = 1; cyc8(0, '0); ack8 = 0;

    // full DLEN=512 frame
    q5.push_back(pexp(0));
    cyc5(1, MK);
    for (int i = 0; i < 86; i++) cyc5(1, pbeat(i, 0));
    check("t5_dv", dv5, 1);
    check("t5_busy", busy5, 0);
    ack5 = 1; cyc5(0, '0); ack5 = 0;
    check("t5_dv_after_ack", dv5, 0);

    // reset mid-collect
    cyc5(1, MK);
    for (int i = 0; i < 40; i++) cyc5(1, pbeat(i, 1));
    check("t6_busy_pre", busy5, 1);
    rst5 = 1; cyc5(1, pbeat(40, 1)); rst5 = 0;
    check("t6_data_zero", (data5 == '0), 1);
    check("t6_dv", dv5, 0);
    check("t6_busy", busy5, 0);
    check("t6_err", err5, 0);
    check("t6_drop", drop5, 0);
    for (int i = 41; i < 86; i++) cyc5(1, pbeat(i, 1));
    check("t6_ignored_busy", busy5, 0);
    check("t6_ignored_dv", dv5, 0);
    q5.push_back(pexp(1));
    cyc5(1, MK);
    for (int i = 0; i < 86; i++) cyc5(1, pbeat(i, 1));
    check("t6_new_frame_dv", dv5, 1);
    ack5 = 1; cyc5(0, '0); ack5 = 0;

    repeat (3) cyc8(0, '0);
    check("pending_frames8", q8.size(), 0);
    check("pending_frames512", q5.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
